// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and helpers for the chunked adder/subtractor
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Chunk index counter width; never narrower than one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/fa_chunk.sv
// rtl/fa_chunk.sv - combinational CHUNK-bit ripple adder with carry into the top bit
module fa_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i0,
    input  logic [CHUNK-1:0] i1,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic w_c;
        sum   = '0;
        c_msb = 1'b0;
        w_c   = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = w_c;
            end
            sum[i] = i0[i] ^ i1[i] ^ w_c;
            w_c    = (i0[i] & i1[i]) | (w_c & (i0[i] ^ i1[i]));
        end
        cout = w_c;
    end

endmodule

// File: rtl/addsub_chunked.sv
// rtl/addsub_chunked.sv - multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock
module addsub_chunked
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_cout;
    logic              r_ovf;
    logic              r_out_valid;
    logic [IDXW-1:0]   r_idx;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK-1:0]  w_sum_chunk;
    logic              w_cout_chunk;
    logic              w_c_msb;
    logic [WIDTH-1:0]  w_res_merged;
    logic              w_last;

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    assign w_last    = (r_idx == LAST_IDX);

    fa_chunk #(.CHUNK(CHUNK)) u_fa (
        .i0    (w_a_chunk),
        .i1    (w_b_chunk),
        .cin   (r_carry),
        .sum   (w_sum_chunk),
        .cout  (w_cout_chunk),
        .c_msb (w_c_msb)
    );

    // Final edge publishes the result including the slice being computed now.
    always_comb begin
        w_res_merged = r_res;
        w_res_merged[r_idx*CHUNK +: CHUNK] = w_sum_chunk;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~borrow.
                        r_a     <= i0;
                        r_b     <= sub ? ~i1 : i1;
                        r_carry <= cin ^ sub;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_res   <= w_res_merged;
                    r_carry <= w_cout_chunk;
                    if (w_last) begin
                        r_sum       <= w_res_merged;
                        r_cout      <= w_cout_chunk;
                        r_ovf       <= w_c_msb ^ w_cout_chunk;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && rst_n;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_addsub_chunked.sv
// tb/tb_addsub_chunked.sv - directed self-checking bench for addsub_chunked
module tb_addsub_chunked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] i0, i1, sum;

    logic        p_in_valid, p_in_ready, p_cin, p_sub, p_out_valid, p_out_ready, p_cout, p_ovf;
    logic [7:0]  p_i0, p_i1, p_sum;
    logic        q_in_valid, q_in_ready, q_cin, q_sub, q_out_valid, q_out_ready, q_cout, q_ovf;
    logic [7:0]  q_i0, q_i1, q_sum;

    addsub_chunked #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i0(i0), .i1(i1), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    addsub_chunked #(.WIDTH(8), .CHUNK(8)) u_dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .i0(p_i0), .i1(p_i1), .cin(p_cin), .sub(p_sub), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .sum(p_sum), .cout(p_cout), .ovf(p_ovf)
    );

    addsub_chunked #(.WIDTH(8), .CHUNK(4)) u_dut_q (
        .clk(clk), .rst_n(rst_n), .in_valid(q_in_valid), .in_ready(q_in_ready),
        .i0(q_i0), .i1(q_i1), .cin(q_cin), .sub(q_sub), .out_valid(q_out_valid),
        .out_ready(q_out_ready), .sum(q_sum), .cout(q_cout), .ovf(q_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;
    int last_acc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s, input logic [31:0] esum,
                         input logic ecout, input logic eovf);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, " ready_timeout"}, 64'(w < 20), 64'd1);
        in_valid = 1'b1;
        i0 = a;
        i1 = b;
        cin = c;
        sub = s;
        tick();
        last_acc = cyc;
        in_valid = 1'b0;
        i0 = $urandom;
        i1 = $urandom;
        cin = ~c;
        sub = ~s;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " sum"}, 64'(sum), 64'(esum));
        check({tag, " cout"}, 64'(cout), 64'(ecout));
        check({tag, " ovf"}, 64'(ovf), 64'(eovf));
    endtask

    task automatic small_op(input string tag,
                            input logic [7:0] pa, input logic [7:0] pb, input logic pc, input logic ps,
                            input logic [7:0] pe, input logic pco, input logic pov,
                            input logic [7:0] qa, input logic [7:0] qb, input logic qc, input logic qs,
                            input logic [7:0] qe, input logic qco, input logic qov);
        int lp;
        int lq;
        p_in_valid = 1'b1; p_i0 = pa; p_i1 = pb; p_cin = pc; p_sub = ps;
        q_in_valid = 1'b1; q_i0 = qa; q_i1 = qb; q_cin = qc; q_sub = qs;
        tick();
        p_in_valid = 1'b0; p_i0 = 8'h00; p_i1 = 8'h00;
        q_in_valid = 1'b0; q_i0 = 8'h00; q_i1 = 8'h00;
        lp = -1;
        lq = -1;
        for (int k = 0; k < 6; k++) begin
            if (p_out_valid && lp < 0) lp = k;
            if (q_out_valid && lq < 0) lq = k;
            tick();
        end
        check({tag, " p latency"}, 64'(lp), 64'd1);
        check({tag, " q latency"}, 64'(lq), 64'd2);
        check({tag, " p sum"}, 64'({p_sum, p_cout, p_ovf}), 64'({pe, pco, pov}));
        check({tag, " q sum"}, 64'({q_sum, q_cout, q_ovf}), 64'({qe, qco, qov}));
        p_out_ready = 1'b1;
        q_out_ready = 1'b1;
        tick();
        p_out_ready = 1'b0;
        q_out_ready = 1'b0;
        check({tag, " consumed"}, 64'({p_out_valid, q_out_valid, p_in_ready, q_in_ready}), 64'b0011);
    endtask

    initial begin
        logic [31:0] held;
        int acc0;
        int acc1;
        rst_n = 1'b0;
        in_valid = 1'b0; i0 = '0; i1 = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        p_in_valid = 1'b0; p_i0 = '0; p_i1 = '0; p_cin = 1'b0; p_sub = 1'b0; p_out_ready = 1'b0;
        q_in_valid = 1'b0; q_i0 = '0; q_i1 = '0; q_cin = 1'b0; q_sub = 1'b0; q_out_ready = 1'b0;
        tick();
        tick();
        check("in_ready held low in reset", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        check("reset outputs", 64'({out_valid, cout, ovf, in_ready}), 64'b0001);
        check("reset sum", 64'(sum), 64'd0);

        small_op("s1", 8'd29, 8'd5, 1'b0, 1'b0, 8'd34, 1'b0, 1'b0,
                       8'd78, 8'd255, 1'b0, 1'b0, 8'd77, 1'b1, 1'b0);
        small_op("s2", 8'd10, 8'd20, 1'b1, 1'b1, 8'd245, 1'b0, 1'b0,
                       8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        do_op("max_pos_inc", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("chunk_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0);
        do_op("wrap_cin", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        do_op("sub_borrow_ovf", 32'h8000_0000, 32'h0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure: the result must hold and a stray in_valid must be dropped.
        tick();
        out_ready = 1'b0;
        do_op("bp", 32'd100, 32'd30, 1'b0, 1'b1, 32'd70, 1'b1, 1'b0);
        held = sum;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 2);
            i0 = 32'h1111_1111;
            i1 = 32'h2222_2222;
            tick();
            check("bp hold", 64'({out_valid, in_ready, cout, ovf}), 64'b1010);
            check("bp sum", 64'(sum), 64'(held));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp consume", 64'({out_valid, in_ready}), 64'b01);
        check("bp sum kept", 64'(sum), 64'd70);
        do_op("bp next", 32'd1000, 32'd234, 1'b0, 1'b0, 32'd1234, 1'b0, 1'b0);

        // Reset lands on the edge that would process chunk 2.
        tick();
        in_valid = 1'b1;
        i0 = 32'hFFFF_FFFF;
        i1 = 32'h0000_0001;
        cin = 1'b0;
        sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid-run reset outputs", 64'({out_valid, in_ready, cout, ovf}), 64'b0000);
        check("mid-run reset sum", 64'(sum), 64'd0);
        rst_n = 1'b1;
        #1;
        check("after reset in_ready", 64'(in_ready), 64'd1);
        tick();
        check("no late result", 64'(out_valid), 64'd0);
        do_op("post reset", 32'd200, 32'd95, 1'b0, 1'b0, 32'd295, 1'b0, 1'b0);

        // Back-to-back issue with out_ready tied high.
        tick();
        do_op("b2b0", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);
        acc0 = last_acc;
        do_op("b2b1", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        acc1 = last_acc;
        check("issue interval 1", 64'(acc1 - acc0), 64'd6);
        do_op("b2b2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        check("issue interval 2", 64'(last_acc - acc1), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
